// File: rtl/gb_hdma_pkg.sv
// gb_hdma_pkg: shared constants and types for the GBC VRAM DMA engine.
//  - register offsets FF51..FF55 (low byte of the CPU address)
//  - FSM state encoding
//  - default block geometry
package gb_hdma_pkg;

  localparam logic [7:0] REG_SRC_HI = 8'h51;
  localparam logic [7:0] REG_SRC_LO = 8'h52;
  localparam logic [7:0] REG_DST_HI = 8'h53;
  localparam logic [7:0] REG_DST_LO = 8'h54;
  localparam logic [7:0] REG_CTRL   = 8'h55;

  localparam int BLOCK_BYTES_DEF = 16;
  localparam int LEN_W_DEF       = 7;

  typedef enum logic [2:0] {
    IDLE,
    GDMA_RD,
    GDMA_WR,
    HDMA_WAIT,
    HDMA_RD,
    HDMA_WR
  } state_t;

  // True while a block is actively being copied (CPU must be held).
  function automatic logic is_copy(input state_t s);
    return (s == GDMA_RD) || (s == GDMA_WR) || (s == HDMA_RD) || (s == HDMA_WR);
  endfunction

endpackage

// File: rtl/gb_hdma_if.sv
// gb_hdma_if: CPU register bus plus the source-read / VRAM-write path of the DMA.
//  slave  : the DMA engine side (decodes registers, drives source and VRAM buses)
//  master : the system side (CPU, source memory, VRAM)
//  cpu_sel_reg/cpu_addr/cpu_wr/cpu_di -> register access; cpu_do read data; cpu_stall CPU hold
//  src_rd/src_addr -> source read request; src_data returned one ce cycle later
//  vram_addr/vram_wren/vram_di -> VRAM byte write
interface gb_hdma_if;
  logic        cpu_sel_reg;
  logic [7:0]  cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        cpu_stall;
  logic        src_rd;
  logic [15:0] src_addr;
  logic [7:0]  src_data;
  logic [12:0] vram_addr;
  logic        vram_wren;
  logic [7:0]  vram_di;

  modport slave (
    input  cpu_sel_reg, cpu_addr, cpu_wr, cpu_di, src_data,
    output cpu_do, cpu_stall, src_rd, src_addr, vram_addr, vram_wren, vram_di
  );

  modport master (
    output cpu_sel_reg, cpu_addr, cpu_wr, cpu_di, src_data,
    input  cpu_do, cpu_stall, src_rd, src_addr, vram_addr, vram_wren, vram_di
  );
endinterface

// File: rtl/gb_hblank_edge.sv
// gb_hblank_edge: registers the video mode on ce and emits a one-ce-cycle pulse
// on the cycle the mode enters 0 (HBlank).
//  clk_sys, reset (sync, active high), ce : clocking
//  lcd_mode     : current video mode
//  hblank_pulse : high for one ce cycle on entry to HBlank
module gb_hblank_edge (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] lcd_mode,
  output logic       hblank_pulse
);
  logic [1:0] mode_q;

  always_ff @(posedge clk_sys) begin
    if (reset)   mode_q <= 2'd0;
    else if (ce) mode_q <= lcd_mode;
  end

  assign hblank_pulse = ce && (lcd_mode == 2'd0) && (mode_q != 2'd0);
endmodule

// File: rtl/gb_hdma.sv
// gb_hdma: GBC VRAM DMA engine (FF51-FF55). Copies BLOCK_BYTES-byte blocks from
// the CPU address space to VRAM, either all at once (GDMA) or one block per
// HBlank (HDMA). Each byte takes two ce cycles: a source read, then a VRAM write.
//  clk_sys, reset (sync, active high), ce : clocking
//  lcd_mode, lcd_on : video status used to pace HDMA
//  bus (gb_hdma_if.slave) : register access, cpu_stall, source read, VRAM write
module gb_hdma
  import gb_hdma_pkg::*;
#(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int LEN_W       = LEN_W_DEF
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] lcd_mode,
  input  logic       lcd_on,
  gb_hdma_if.slave   bus
);
  localparam int BW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

  state_t           state, state_nx;
  logic [15:0]      src;
  logic [12:0]      dst;
  logic [LEN_W-1:0] remaining;
  logic [BW-1:0]    byte_cnt;
  logic             hblank;
  logic             reg_wr, ctrl_wr, is_wr, block_end;
  logic             src_rd, vram_wren, cpu_stall;

  gb_hblank_edge u_hblank (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce           (ce),
    .lcd_mode     (lcd_mode),
    .hblank_pulse (hblank)
  );

  assign reg_wr    = ce && bus.cpu_wr && bus.cpu_sel_reg;
  assign ctrl_wr   = reg_wr && (bus.cpu_addr == REG_CTRL);
  assign is_wr     = (state == GDMA_WR) || (state == HDMA_WR);
  assign block_end = is_wr && (byte_cnt == BW'(BLOCK_BYTES - 1));

  always_ff @(posedge clk_sys) begin
    if (reset)   state <= IDLE;
    else if (ce) state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    src_rd    = 1'b0;
    vram_wren = 1'b0;
    cpu_stall = is_copy(state);
    case (state)
      IDLE:
        if (ctrl_wr) begin
          // HDMA started with the LCD off copies its first block straight away.
          if (bus.cpu_di[7]) state_nx = lcd_on ? HDMA_WAIT : HDMA_RD;
          else               state_nx = GDMA_RD;
        end
      GDMA_RD: begin
        src_rd   = 1'b1;
        state_nx = GDMA_WR;
      end
      GDMA_WR: begin
        vram_wren = ce;
        if (block_end) state_nx = (remaining == '0) ? IDLE : GDMA_RD;
        else           state_nx = GDMA_RD;
      end
      HDMA_WAIT:
        if (ctrl_wr && !bus.cpu_di[7]) state_nx = IDLE;
        else if (hblank)               state_nx = HDMA_RD;
      HDMA_RD: begin
        src_rd   = 1'b1;
        state_nx = HDMA_WR;
      end
      HDMA_WR: begin
        vram_wren = ce;
        if (block_end) state_nx = (remaining == '0) ? IDLE : HDMA_WAIT;
        else           state_nx = HDMA_RD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address/count datapath. Copy updates take priority; register writes are
  // only honoured outside an active block (CPU is stalled then anyway).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '1;
      byte_cnt  <= '0;
    end else if (ce) begin
      if (is_wr) begin
        src      <= src + 16'd1;
        dst      <= dst + 13'd1;
        byte_cnt <= block_end ? '0 : byte_cnt + 1'b1;
        if (block_end) remaining <= remaining - 1'b1;  // 0 wraps to all-ones
      end else if (reg_wr && !is_copy(state)) begin
        case (bus.cpu_addr)
          REG_SRC_HI: src[15:8] <= bus.cpu_di;
          REG_SRC_LO: src[7:0]  <= {bus.cpu_di[7:4], 4'h0};
          REG_DST_HI: dst[12:8] <= bus.cpu_di[4:0];
          REG_DST_LO: dst[7:0]  <= {bus.cpu_di[7:4], 4'h0};
          REG_CTRL:
            if (state == IDLE || bus.cpu_di[7]) begin
              remaining <= bus.cpu_di[LEN_W-1:0];
              byte_cnt  <= '0;
            end
          default: ;
        endcase
      end
    end
  end

  // Idle reads give {1,remaining}: 0xFF after completion (remaining wrapped),
  // 0x80|remaining after an abort.
  assign bus.cpu_do    = (bus.cpu_sel_reg && bus.cpu_addr == REG_CTRL) ?
                         {state == IDLE, remaining} : 8'hFF;
  assign bus.cpu_stall = cpu_stall;
  assign bus.src_rd    = src_rd;
  assign bus.src_addr  = src;
  assign bus.vram_addr = dst;
  assign bus.vram_wren = vram_wren;
  assign bus.vram_di   = bus.src_data;
endmodule
